// File: rtl/clk_pkg.sv
// Shared clocking constants for the game core: board clock rate, game-tick
// length and the derived half-period of the 100 ms tick clock.
package clk_pkg;

    localparam int SYS_CLK_HZ = 100_000_000;
    localparam int TICK_MS    = 100;

    // Input cycles per half of the game-tick period (5_000_000 at 100 MHz / 100 ms).
    localparam int HALF_PERIOD = SYS_CLK_HZ / 1000 * TICK_MS / 2;

    localparam int DIV_WIDTH = 32;
    localparam int HP_WIDTH  = 23;

    // True when a non-negative value is representable in 'width' unsigned bits.
    function automatic bit fits_width(input longint value, input int width);
        return (value >= 0) && ((value >> width) == 0);
    endfunction

endpackage : clk_pkg

// File: rtl/free_run_counter.sv
// Free-running up counter, modulo 2^WIDTH, with an asynchronous active-high
// reset and a synchronous preset port (tied off in normal use).
module free_run_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count
);

    // Count up every edge; the all-ones value rolls over to zero silently.
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values, and reset sits in the sensitivity list to act asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

endmodule : free_run_counter

// File: rtl/clk_gen_100ms.sv
// Game-core clock generator: a free-running cycle counter (clk_div) and a
// 50%-duty game-tick clock (clk_100ms) with a one-cycle rising-edge pulse.
module clk_gen_100ms #(
    parameter int DIV_WIDTH   = clk_pkg::DIV_WIDTH,
    parameter int HALF_PERIOD = clk_pkg::HALF_PERIOD,
    parameter int HP_WIDTH    = clk_pkg::HP_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [DIV_WIDTH-1:0] clk_div,
    output logic                 clk_100ms,
    output logic                 tick_100ms
);

    // Reject half-periods that are zero or cannot be held by the counter.
    generate
        if (HALF_PERIOD < 1 || !clk_pkg::fits_width(longint'(HALF_PERIOD) - 1, HP_WIDTH)) begin : g_bad_half_period
            $error("clk_gen_100ms: HALF_PERIOD=%0d must be >= 1 and HALF_PERIOD-1 must fit in %0d bits",
                   HALF_PERIOD, HP_WIDTH);
        end
    endgenerate

    localparam logic [HP_WIDTH-1:0] HP_LAST = HP_WIDTH'(HALF_PERIOD - 1);

    logic [HP_WIDTH-1:0]  hp_cnt;
    logic                 div_load;
    logic [DIV_WIDTH-1:0] div_load_value;

    // Preset hook of the cycle counter; never used in the running design.
    assign div_load       = 1'b0;
    assign div_load_value = '0;

    free_run_counter #(
        .WIDTH (DIV_WIDTH)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .load       (div_load),
        .load_value (div_load_value),
        .count      (clk_div)
    );

    // Half-period counter; clk_100ms and tick_100ms are both straight flop outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp_cnt     <= '0;
            clk_100ms  <= 1'b0;
            tick_100ms <= 1'b0;
        end else if (hp_cnt == HP_LAST) begin
            hp_cnt     <= '0;
            clk_100ms  <= ~clk_100ms;
            tick_100ms <= ~clk_100ms;
        end else begin
            hp_cnt     <= hp_cnt + HP_WIDTH'(1);
            tick_100ms <= 1'b0;
        end
    end

endmodule : clk_gen_100ms

// File: tb/tb_clk_gen_100ms.sv
// Directed bench for clk_gen_100ms: a HALF_PERIOD=4 instance for the main
// scenarios and a HALF_PERIOD=1 instance for the every-cycle toggle case.
module tb_clk_gen_100ms;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] clk_div;
    logic        clk_100ms;
    logic        tick_100ms;
    logic [31:0] clk_div_1;
    logic        clk_100ms_1;
    logic        tick_100ms_1;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    clk_gen_100ms #(
        .DIV_WIDTH   (32),
        .HALF_PERIOD (4),
        .HP_WIDTH    (23)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div),
        .clk_100ms  (clk_100ms),
        .tick_100ms (tick_100ms)
    );

    clk_gen_100ms #(
        .DIV_WIDTH   (32),
        .HALF_PERIOD (1),
        .HP_WIDTH    (23)
    ) dut_hp1 (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div_1),
        .clk_100ms  (clk_100ms_1),
        .tick_100ms (tick_100ms_1)
    );

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Pulse reset for one cycle, releasing at a falling edge; next rise is edge 1.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        edge_n = 0;
    endtask

    // Expected tick clock for HALF_PERIOD=4, e edges after release.
    function automatic logic exp_clk4(input int e);
        return ((e / 4) % 2) == 1;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (clk_div !== 32'd0 || clk_100ms !== 1'b0 || tick_100ms !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: clk_div=%h clk_100ms=%b tick=%b, required 0/0/0",
                         i, clk_div, clk_100ms, tick_100ms);
            end
            checks++;
            if (clk_div_1 !== 32'd0 || clk_100ms_1 !== 1'b0 || tick_100ms_1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold_hp1 cycle %0d: clk_div=%h clk_100ms=%b tick=%b, required 0/0/0",
                         i, clk_div_1, clk_100ms_1, tick_100ms_1);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        edge_n = 0;
        repeat (5) step();
        checks++;
        if (clk_div !== 32'd5) begin
            errors++;
            $display("FAIL reset_release_count: clk_div=%0d, required 5", clk_div);
        end
    endtask

    task automatic test_period();
        apply_reset();
        for (int i = 0; i < 64; i++) begin
            step();
            checks++;
            if (clk_100ms !== exp_clk4(edge_n) || tick_100ms !== ((edge_n % 8) == 4) ||
                clk_div !== 32'(edge_n)) begin
                errors++;
                $display("FAIL period edge %0d: clk_100ms=%b tick=%b clk_div=%0d, required %b/%b/%0d",
                         edge_n, clk_100ms, tick_100ms, clk_div,
                         exp_clk4(edge_n), (edge_n % 8) == 4, edge_n);
            end
        end
    endtask

    // Runs straight after test_period so the tick-clock phase carries on.
    task automatic test_wrap();
        logic [31:0] exp_div [3];
        exp_div[0] = 32'hFFFF_FFFE;
        exp_div[1] = 32'hFFFF_FFFF;
        exp_div[2] = 32'h0000_0000;
        @(negedge clk);
        force dut.div_load = 1'b1;
        force dut.div_load_value = 32'hFFFF_FFFE;
        step();
        release dut.div_load;
        release dut.div_load_value;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            checks++;
            if (clk_div !== exp_div[i] || clk_100ms !== exp_clk4(edge_n) ||
                tick_100ms !== ((edge_n % 8) == 4)) begin
                errors++;
                $display("FAIL wrap step %0d: clk_div=%h clk_100ms=%b tick=%b, required %h/%b/%b",
                         i, clk_div, clk_100ms, tick_100ms, exp_div[i],
                         exp_clk4(edge_n), (edge_n % 8) == 4);
            end
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        repeat (37) step();
        checks++;
        if (clk_div !== 32'd37 || clk_100ms !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_setup: clk_div=%0d clk_100ms=%b, required 37/1", clk_div, clk_100ms);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (clk_div !== 32'd0 || clk_100ms !== 1'b0 || tick_100ms !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async_clear: clk_div=%h clk_100ms=%b tick=%b, required 0/0/0",
                     clk_div, clk_100ms, tick_100ms);
        end
        #1 rst = 1'b0;
        edge_n = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (clk_100ms !== (i == 4) || tick_100ms !== (i == 4) || clk_div !== 32'(i)) begin
                errors++;
                $display("FAIL mid_reset_first_rise edge %0d: clk_100ms=%b tick=%b clk_div=%0d, required %b/%b/%0d",
                         i, clk_100ms, tick_100ms, clk_div, i == 4, i == 4, i);
            end
        end
    endtask

    task automatic test_half_period_one();
        apply_reset();
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if (clk_100ms_1 !== ((i % 2) == 1) || tick_100ms_1 !== ((i % 2) == 1)) begin
                errors++;
                $display("FAIL hp1 edge %0d: clk_100ms=%b tick=%b, required %b/%b",
                         i, clk_100ms_1, tick_100ms_1, (i % 2) == 1, (i % 2) == 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_period();
        test_wrap();
        test_mid_reset();
        test_half_period_one();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clk_gen_100ms
